// File: rtl/piso_register.sv
// piso_register: parallel-in serial-out shifter with a valid/ready serial handshake
// and a one-cycle done pulse after the final bit of each word.
module piso_register #(
    parameter int DataSize = 8,
    parameter bit MsbFirst = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DataSize-1:0] d,
    output logic                ready,
    output logic                sdata,
    output logic                svalid,
    input  logic                sready,
    output logic                last,
    output logic                done
);
    localparam int CntW = $clog2(DataSize);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              r_state;
    state_t              w_next;
    logic [DataSize-1:0] r_shift;
    logic [CntW-1:0]     r_cnt;
    logic                w_load;
    logic                w_xfer;
    logic                w_out_bit;
    assign w_load    = (r_state == IDLE) && load;
    assign w_xfer    = svalid && sready;
    assign w_out_bit = MsbFirst ? r_shift[DataSize-1] : r_shift[0];
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)  ? (load ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? ((w_xfer && r_cnt == '0) ? DONE : SHIFT) :
                                      IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Loads only land in IDLE, so a busy-time load never touches the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= d;
            r_cnt   <= CntW'(DataSize - 1);
        end else if (w_xfer) begin
            r_shift <= MsbFirst ? {r_shift[DataSize-2:0], 1'b0} : {1'b0, r_shift[DataSize-1:1]};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end
    assign ready  = (r_state == IDLE);
    assign svalid = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign sdata  = svalid && w_out_bit;
    assign last   = svalid && (r_cnt == '0);
endmodule

// File: tb/tb_piso_register.sv
// tb_piso_register: directed checks of an MSB-first and an LSB-first instance
// driven from the same stimulus.
module tb_piso_register;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       sready = 1'b0;
    logic [7:0] d = 8'h00;
    logic       ready_m, sdata_m, svalid_m, last_m, done_m;
    logic       ready_l, sdata_l, svalid_l, last_l, done_l;
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] got;
    logic [9:0] want;

    always #5 clk = ~clk;

    piso_register #(.DataSize(8), .MsbFirst(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .ready(ready_m), .sdata(sdata_m),
        .svalid(svalid_m), .sready(sready), .last(last_m), .done(done_m)
    );
    piso_register #(.DataSize(8), .MsbFirst(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .ready(ready_l), .sdata(sdata_l),
        .svalid(svalid_l), .sready(sready), .last(last_l), .done(done_l)
    );

    // got/want order: sdata_m sdata_l svalid_m svalid_l last_m last_l ready_m ready_l done_m done_l
    always_comb got = {sdata_m, sdata_l, svalid_m, svalid_l, last_m, last_l,
                       ready_m, ready_l, done_m, done_l};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        want = 10'b00_00_00_11_00;
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_init: got %b want %b", got, want);
        end
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_idle: got %b want %b", got, want);
        end
    endtask

    // em/el: expected serial sequences, leftmost bit sent first
    task automatic send(input string name, input logic [7:0] dv, input logic [7:0] em,
                        input logic [7:0] el, input int stall_len, input bit busy_load);
        d = dv;
        load = 1'b1;
        sready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy_load && i == 3) begin
                load = 1'b1;
                d = 8'hFF;
            end
            if (i == 2) begin
                for (int s = 0; s < stall_len; s++) begin
                    sready = 1'b0;
                    want = {em[5], el[5], 2'b11, 2'b00, 4'b0000};
                    n_vec++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL %s stall%0d: got %b want %b", name, s, got, want);
                    end
                    step();
                end
                sready = 1'b1;
            end
            want = {em[7-i], el[7-i], 2'b11, {2{i == 7}}, 4'b0000};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s bit%0d: got %b want %b", name, i, got, want);
            end
            step();
            load = 1'b0;
            d = dv;
        end
        want = 10'b00_00_00_00_11;
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s done: got %b want %b", name, got, want);
        end
        step();
        want = 10'b00_00_00_11_00;
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s ready: got %b want %b", name, got, want);
        end
        step();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s idle_after: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_msb_first();
        send("msb_a5", 8'hA5, 8'b10100101, 8'b10100101, 0, 1'b0);
    endtask

    task automatic test_lsb_first();
        send("lsb_0f", 8'h0F, 8'b00001111, 8'b11110000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        send("bp_a5", 8'hA5, 8'b10100101, 8'b10100101, 3, 1'b0);
    endtask

    task automatic test_load_busy();
        send("busy_a5", 8'hA5, 8'b10100101, 8'b10100101, 0, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] em;
        em = 8'b10100101;
        d = 8'hA5;
        load = 1'b1;
        sready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            want = {em[7-i], em[7-i], 2'b11, 2'b00, 4'b0000};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mid_bit%0d: got %b want %b", i, got, want);
            end
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        want = 10'b00_00_00_11_00;
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL mid_async_reset: got %b want %b", got, want);
        end
        step();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL mid_reset_held: got %b want %b", got, want);
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL mid_no_done: got %b want %b", got, want);
        end
        send("post_3c", 8'h3C, 8'b00111100, 8'b00111100, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_load_busy();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/piso_register.md
PISO_REGISTER -- requirements
Module: piso_register

Interface
REQ-001 SHALL provide parameter DataSize, default 8, word width in bits; legal range DataSize >= 2.
REQ-002 SHALL provide parameter MsbFirst, default 1; 1 sends the MSB first, 0 sends the LSB first.
REQ-003 SHALL use one clock and a reset that is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  request to capture d; sampled on the rising edge.
REQ-007 d  input  DataSize  parallel word to serialize.
REQ-008 ready  output  1  block is idle and will accept load.
REQ-009 sdata  output  1  current serial bit.
REQ-010 svalid  output  1  sdata is valid.
REQ-011 sready  input  1  downstream accepts sdata this cycle.
REQ-012 last  output  1  current bit is the final bit of the word.
REQ-013 done  output  1  one-cycle pulse after the final bit transfers.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE, plus a DataSize-bit shift register and a bit counter of width clog2(DataSize).
REQ-015 IDLE: ready=1, svalid=0, done=0; on a rising edge with load=1, capture d, set counter=DataSize-1 and go to SHIFT.
REQ-016 load=1 outside IDLE SHALL be ignored; the shift register is not modified and no word is queued.
REQ-017 SHIFT: ready=0, svalid=1; sdata = shift register bit DataSize-1 when MsbFirst=1, bit 0 when MsbFirst=0.
REQ-018 A transfer SHALL occur on a rising edge with svalid=1 and sready=1; only a transfer shifts the register by one position toward the output end and decrements the counter.
REQ-019 With sready=0 in SHIFT, sdata, svalid, last and the counter SHALL hold their values.
REQ-020 last SHALL equal svalid AND (counter==0).
REQ-021 A transfer with counter==0 SHALL move the state to DONE; the counter SHALL never wrap below 0.
REQ-022 DONE: done=1, ready=0, svalid=0 for exactly one cycle, then unconditional return to IDLE.
REQ-023 Latency SHALL be as follows: a load captured at edge N gives svalid=1 from edge N onward.
REQ-024 With sready held at 1, bits SHALL transfer at edges N+1 to N+DataSize, done=1 in the cycle after edge N+DataSize, and ready=1 one cycle later.
REQ-025 Minimum word period SHALL be DataSize+2 cycles.
REQ-026 sdata SHALL be 0 whenever svalid=0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, shift register=0, counter=0, sdata=0, svalid=0, last=0, done=0, ready=1, without waiting for clk.
REQ-028 Reset during SHIFT or DONE SHALL abort the word; no done pulse is produced for it.
REQ-029 After rst_n deasserts, the first load SHALL start a clean word.

Verification
REQ-030 Reset check: drive rst_n=0 mid-cycle -> ready=1, svalid=0, sdata=0, last=0, done=0 before the next clk edge.
REQ-031 MSB-first check: DataSize=8, MsbFirst=1, d=8'hA5, one-cycle load pulse, sready=1 -> sdata 1,0,1,0,0,1,0,1 over 8 consecutive cycles, last=1 only on the 8th bit, done=1 the next cycle, ready=1 the cycle after.
REQ-032 LSB-first check: MsbFirst=0, d=8'h0F, sready=1 -> sdata 1,1,1,1,0,0,0,0, then done pulse.
REQ-033 Backpressure check: d=8'hA5 MSB-first, sready=0 for 3 cycles after the 2nd transfer -> sdata=1 and svalid=1 held all 3 cycles, still exactly 8 transfers, done 3 cycles later than the REQ-031 timing.
REQ-034 Load-while-busy check: load d=8'hFF during SHIFT of word 8'hA5 -> output sequence unchanged from 8'hA5, ready stays 0, no second word follows.
REQ-035 Reset mid-word check: rst_n=0 after 4 transfers -> immediate IDLE, no done pulse; after release, load 8'h3C -> sdata 0,0,1,1,1,1,0,0 (MSB first) and a normal done pulse.
